// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and widths for the ARMINx8 fetch path. The
//                branch-target LUT, the decoder and the fetch controller all
//                agree on the program-counter and offset widths through here.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int PC_W  = 12;
    localparam int OFF_W = 8;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_fetch_ctrl_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selector. Priority, highest first:
//                halt (hold), stall (hold), absolute jump, relative jump,
//                sequential increment. All arithmetic wraps modulo 2**PC_W.
//  Ports       : i_pc        current program counter
//                i_halt      halt decoded at i_pc
//                i_stall     multi-cycle op in flight
//                i_jump_abs  take absolute branch to i_target
//                i_target    absolute branch target
//                i_jump_rel  take relative branch by i_offset
//                i_offset    two's-complement displacement
//                o_pc_next   selected next program counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel #(
    parameter int PC_W  = 12,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_halt,
    input  logic             i_stall,
    input  logic             i_jump_abs,
    input  logic [PC_W-1:0]  i_target,
    input  logic             i_jump_rel,
    input  logic [OFF_W-1:0] i_offset,
    output logic [PC_W-1:0]  o_pc_next
);

    // Sign-extend the displacement to the PC width; the add then wraps
    // naturally because the result is truncated to PC_W bits.
    logic [PC_W-1:0] w_off_ext;
    assign w_off_ext = PC_W'($signed(i_offset));

    always_comb begin
        o_pc_next = i_pc;
        if (i_halt || i_stall) begin
            o_pc_next = i_pc;
        end else if (i_jump_abs) begin
            o_pc_next = i_target;
        end else if (i_jump_rel) begin
            o_pc_next = i_pc + w_off_ext;
        end else begin
            o_pc_next = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Program counter and fetch sequencer. Owns the start/halt
//                handshake, the registered instruction address and a
//                saturating retired-instruction counter.
//  Ports       : Clk          system clock, rising edge
//                Reset        asynchronous active-low reset
//                Start        begin execution at START_ADDR (IDLE/HALT only)
//                Halt_req     halt instruction at Prog_addr
//                Stall        hold PC and counter this cycle
//                Jump_abs     taken absolute branch, load Target
//                Target       absolute branch target
//                Jump_rel     taken relative branch, add Offset
//                Offset       signed displacement
//                Prog_addr    current instruction address (registered)
//                Fetch_valid  high in RUN
//                Done         high in HALT
//                Instr_cnt    instructions retired since last Start
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter int                     PC_W       = pc_pkg::PC_W,
    parameter int                     OFF_W      = pc_pkg::OFF_W,
    parameter logic [PC_W-1:0]        START_ADDR = '0,
    parameter int                     CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt_req,
    input  logic              Stall,
    input  logic              Jump_abs,
    input  logic [PC_W-1:0]   Target,
    input  logic              Jump_rel,
    input  logic [OFF_W-1:0]  Offset,
    output logic [PC_W-1:0]   Prog_addr,
    output logic              Fetch_valid,
    output logic              Done,
    output logic [CNT_W-1:0]  Instr_cnt
);

    import pc_pkg::*;

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    pc_next_sel #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next_sel (
        .i_pc       (r_pc),
        .i_halt     (Halt_req),
        .i_stall    (Stall),
        .i_jump_abs (Jump_abs),
        .i_target   (Target),
        .i_jump_rel (Jump_rel),
        .i_offset   (Offset),
        .o_pc_next  (w_pc_sel)
    );

    // Counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt
                                                : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_pc    <= START_ADDR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, HALT: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_ADDR;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                // A halt retires (counts) but leaves the PC on the halt op.
                if (Halt_req) begin
                    w_state_nxt = HALT;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (!Stall) begin
                    w_pc_nxt    = w_pc_sel;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = START_ADDR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign Prog_addr   = r_pc;
    assign Instr_cnt   = r_cnt;
    assign Fetch_valid = (r_state == RUN);
    assign Done        = (r_state == HALT);

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Self-checking bench for pc_fetch_ctrl. A behavioural model
//                tracks mode, address and retired count with integer
//                arithmetic; every cycle the outputs are compared to it.
//                Directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam int PC_W  = 12;
    localparam int OFF_W = 8;
    localparam int CNT_W = 16;
    localparam int PC_MOD  = 4096;
    localparam int CNT_MAX = 65535;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Halt_req;
    logic              Stall;
    logic              Jump_abs;
    logic [PC_W-1:0]   Target;
    logic              Jump_rel;
    logic [OFF_W-1:0]  Offset;
    logic [PC_W-1:0]   Prog_addr;
    logic              Fetch_valid;
    logic              Done;
    logic [CNT_W-1:0]  Instr_cnt;

    pc_fetch_ctrl #(
        .PC_W       (PC_W),
        .OFF_W      (OFF_W),
        .START_ADDR ('0),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Halt_req    (Halt_req),
        .Stall       (Stall),
        .Jump_abs    (Jump_abs),
        .Target      (Target),
        .Jump_rel    (Jump_rel),
        .Offset      (Offset),
        .Prog_addr   (Prog_addr),
        .Fetch_valid (Fetch_valid),
        .Done        (Done),
        .Instr_cnt   (Instr_cnt)
    );

    always #5 Clk = ~Clk;

    // Model: mode 0 = idle, 1 = running, 2 = halted.
    int m_mode;
    int m_pc;
    int m_cnt;

    int n_total;
    int n_pass;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
    endtask

    function automatic int retire(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    // Apply the rules for one rising edge, given the inputs held across it.
    task automatic model_edge();
        if (!Reset) begin
            model_reset();
        end else if (m_mode != 1) begin
            if (Start) begin
                m_mode = 1;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end else if (Halt_req) begin
            m_mode = 2;
            m_cnt  = retire(m_cnt);
        end else if (!Stall) begin
            m_cnt = retire(m_cnt);
            if (Jump_abs)      m_pc = int'(Target);
            else if (Jump_rel) m_pc = (m_pc + int'($signed(Offset)) + PC_MOD) % PC_MOD;
            else               m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    task automatic compare_all();
        check("prog_addr",   int'(Prog_addr),   m_pc);
        check("fetch_valid", int'(Fetch_valid), (m_mode == 1) ? 1 : 0);
        check("done",        int'(Done),        (m_mode == 2) ? 1 : 0);
        check("instr_cnt",   int'(Instr_cnt),   m_cnt);
    endtask

    // One clock: inputs are already set; update model at the edge, compare
    // on the falling edge.
    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        Start    = 1'b0;
        Halt_req = 1'b0;
        Stall    = 1'b0;
        Jump_abs = 1'b0;
        Jump_rel = 1'b0;
        Target   = PC_W'($urandom);
        Offset   = OFF_W'($urandom);
    endtask

    task automatic do_start();
        idle_inputs();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic do_plain(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_abs(input int t);
        idle_inputs();
        Jump_abs = 1'b1;
        Target   = PC_W'(t);
        tick();
        idle_inputs();
    endtask

    task automatic do_rel(input int off);
        idle_inputs();
        Jump_rel = 1'b1;
        Offset   = OFF_W'(off);
        tick();
        idle_inputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle_inputs();
        Reset = 1'b0;
        model_reset();
        #2;
        check("reset_addr", int'(Prog_addr), 0);
        check("reset_fv",   int'(Fetch_valid), 0);
        check("reset_done", int'(Done), 0);
        check("reset_cnt",  int'(Instr_cnt), 0);
        tick();
        tick();
        Reset = 1'b1;

        // Start, five plain cycles, three stalls.
        do_start();
        check("start_addr", int'(Prog_addr), 0);
        check("start_fv",   int'(Fetch_valid), 1);
        do_plain(5);
        check("plain5_addr", int'(Prog_addr), 5);
        check("plain5_cnt",  int'(Instr_cnt), 5);
        idle_inputs();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("stall_addr", int'(Prog_addr), 5);
        check("stall_cnt",  int'(Instr_cnt), 5);

        // Relative branches, including wrap below zero.
        do_abs(4);
        do_rel(8'hFF);
        check("rel_m1", int'(Prog_addr), 3);
        do_abs(4);
        do_rel(8'h14);
        check("rel_p20", int'(Prog_addr), 24);
        do_abs(0);
        do_rel(8'hFF);
        check("rel_wrap", int'(Prog_addr), 4095);
        do_plain(1);
        check("inc_wrap", int'(Prog_addr), 0);

        // Both jumps asserted: absolute wins.
        do_abs(10);
        idle_inputs();
        Jump_abs = 1'b1;
        Target   = 12'd117;
        Jump_rel = 1'b1;
        Offset   = 8'd3;
        tick();
        check("abs_wins", int'(Prog_addr), 117);

        // Start while running is ignored.
        idle_inputs();
        Start = 1'b1;
        tick();
        check("start_in_run", int'(Prog_addr), 118);

        // Asynchronous reset in the middle of a cycle.
        do_abs(57);
        check("pre_reset_addr", int'(Prog_addr), 57);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check("areset_addr", int'(Prog_addr), 0);
        check("areset_fv",   int'(Fetch_valid), 0);
        check("areset_done", int'(Done), 0);
        check("areset_cnt",  int'(Instr_cnt), 0);
        @(negedge Clk);
        compare_all();
        tick();
        Reset = 1'b1;
        do_plain(2);
        check("idle_ignores", int'(Fetch_valid), 0);
        do_start();
        check("restart_addr", int'(Prog_addr), 0);
        check("restart_fv",   int'(Fetch_valid), 1);

        // Randomised traffic in all modes.
        for (int i = 0; i < 3000; i++) begin
            Start    = ($urandom_range(0, 15) == 0);
            Halt_req = ($urandom_range(0, 63) == 0);
            Stall    = ($urandom_range(0, 4) == 0);
            Jump_abs = ($urandom_range(0, 5) == 0);
            Jump_rel = ($urandom_range(0, 4) == 0);
            Target   = PC_W'($urandom);
            Offset   = OFF_W'($urandom);
            tick();
        end

        // Make sure we are halted, then restart cleanly.
        idle_inputs();
        if (m_mode == 0) do_start();
        if (m_mode == 1) begin
            Halt_req = 1'b1;
            tick();
            Halt_req = 1'b0;
        end
        check("pre_halt_done", int'(Done), 1);
        do_start();
        do_plain(202);
        idle_inputs();
        Halt_req = 1'b1;
        tick();
        check("halt_done", int'(Done), 1);
        check("halt_fv",   int'(Fetch_valid), 0);
        check("halt_addr", int'(Prog_addr), 202);
        check("halt_cnt",  int'(Instr_cnt), 203);
        // Frozen in halt regardless of other inputs.
        for (int i = 0; i < 20; i++) begin
            Halt_req = $urandom_range(0, 1);
            Stall    = $urandom_range(0, 1);
            Jump_abs = $urandom_range(0, 1);
            Jump_rel = $urandom_range(0, 1);
            Target   = PC_W'($urandom);
            Offset   = OFF_W'($urandom);
            tick();
        end
        check("frozen_addr", int'(Prog_addr), 202);
        check("frozen_cnt",  int'(Instr_cnt), 203);
        do_start();
        check("rerun_done", int'(Done), 0);
        check("rerun_addr", int'(Prog_addr), 0);
        check("rerun_cnt",  int'(Instr_cnt), 0);

        // Counter saturation.
        do_plain(70000);
        check("sat_cnt", int'(Instr_cnt), 65535);
        check("sat_fv",  int'(Fetch_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
`default_nettype wire
